// File: rtl/key_event_pkg.sv
// Shared types and helpers for the key event bank: hold-state encoding and
// counter width sizing.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } hold_state_e;

  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/key_event_chan.sv
// One key channel: 2-FF synchroniser, stable-window debouncer and a hold FSM
// producing registered press/release/long/repeat pulses.
module key_event_chan
  import key_event_pkg::*;
#(
  parameter int DEB_CYCLES    = 240000,
  parameter int LONG_CYCLES   = 6000000,
  parameter int REPEAT_CYCLES = 1200000,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int DW = cnt_w(DEB_CYCLES);
  localparam int HW = (cnt_w(LONG_CYCLES) > cnt_w(REPEAT_CYCLES)) ?
                      cnt_w(LONG_CYCLES) : cnt_w(REPEAT_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
  localparam logic          RELEASED  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  hold_state_e   state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;

  logic p, flip, rise, fall;

  // Debounce: a level must disagree with stable for DEB_CYCLES edges in a row
  always_comb begin
    p        = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    flip     = (p != stable_q) && (dcnt_q == DEB_LAST);
    rise     = flip & p;
    fall     = flip & ~p;
    stable_d = flip ? p : stable_q;
    dcnt_d   = ((p == stable_q) || flip) ? '0 : dcnt_q + DW'(1);
  end

  // Hold FSM: a debounced release always takes priority over terminal counts
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          hcnt_d  = '0;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_d   = IDLE;
          hcnt_d    = '0;
          release_d = 1'b1;
        end else if (hcnt_q == LONG_LAST) begin
          state_d = HELD;
          hcnt_d  = '0;
          long_d  = 1'b1;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      HELD: begin
        if (fall) begin
          state_d   = IDLE;
          hcnt_d    = '0;
          release_d = 1'b1;
        end else if (!i_repeat_en) begin
          hcnt_d = '0;
        end else if (hcnt_q == REP_LAST) begin
          hcnt_d   = '0;
          repeat_d = 1'b1;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q   <= RELEASED;
      sync2_q   <= RELEASED;
      stable_q  <= 1'b0;
      dcnt_q    <= '0;
      state_q   <= IDLE;
      hcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= i_key;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      dcnt_q    <= dcnt_d;
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign o_level   = stable_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;

endmodule

// File: rtl/key_event_bank.sv
// N-channel push-button conditioner: one key_event_chan per key plus a
// combined any-event flag.
module key_event_bank
  import key_event_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter int DEB_CYCLES    = 240000,
  parameter int LONG_CYCLES   = 6000000,
  parameter int REPEAT_CYCLES = 1200000,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_key,
  input  logic [N_KEYS-1:0] i_repeat_en,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long,
  output logic [N_KEYS-1:0] o_repeat,
  output logic              o_any_event
);

  if (N_KEYS < 1) begin : g_bad_n
    $error("key_event_bank: N_KEYS must be >= 1");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("key_event_bank: DEB_CYCLES must be >= 1");
  end
  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("key_event_bank: LONG_CYCLES must be >= 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_rep
    $error("key_event_bank: REPEAT_CYCLES must be >= 1");
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_chan
    key_event_chan #(
      .DEB_CYCLES   (DEB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_chan (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_key      (i_key[k]),
      .i_repeat_en(i_repeat_en[k]),
      .o_level    (o_level[k]),
      .o_press    (o_press[k]),
      .o_release  (o_release[k]),
      .o_long     (o_long[k]),
      .o_repeat   (o_repeat[k])
    );
  end

  assign o_any_event = |(o_press | o_release | o_long | o_repeat);

endmodule
